a2d_intf: RTL and testbench



---
 rtl/a2d_pkg.sv | 15 +
 rtl/a2d_intf_spi.sv | 58 +++++
 rtl/a2d_intf.sv | 80 ++++++++
 tb/tb_a2d_intf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion responder and its SPI master.
package a2d_pkg;

  typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} a2d_state_t;

  localparam logic [4:0] DIV_LOAD  = 5'b10111;
  localparam logic [4:0] DIV_DONE  = 5'b11110;
  localparam int         XFER_BITS = 16;

  // ADC128S command frame: channel address in bits [13:11].
  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_intf_spi.sv
// 16-bit SPI master, SCLK = clk/32, idle-high clock; shifts MOSI on fall, samples MISO on rise.
module spi_mstr16
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  logic [4:0]  div;
  logic [4:0]  bit_cnt;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic        all_rise;

  assign all_rise = (bit_cnt == 5'(XFER_BITS));
  assign done     = !SS_n && all_rise && (div == DIV_DONE);
  // SCLK parks high between frames and after the last rising edge.
  assign SCLK     = (SS_n || all_rise) ? 1'b1 : div[4];
  assign MOSI     = tx_sr[15];
  assign rd_data  = rx_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n    <= 1'b1;
      div     <= DIV_LOAD;
      bit_cnt <= '0;
      tx_sr   <= '0;
    end else if (wrt) begin
      SS_n    <= 1'b0;
      div     <= DIV_LOAD;
      bit_cnt <= '0;
      tx_sr   <= cmd;
    end else if (done) begin
      SS_n <= 1'b1;
    end else if (!SS_n) begin
      div <= div + 5'd1;
      if (div == 5'b01111 && !all_rise)
        bit_cnt <= bit_cnt + 5'd1;
      if (div == 5'b11111 && !all_rise)
        tx_sr <= {tx_sr[14:0], 1'b0};
    end
  end

  // Receive shifter holds data only; it is fully overwritten every frame.
  always_ff @(posedge clk) begin
    if (!SS_n && div == 5'b01111 && !all_rise)
      rx_sr <= {rx_sr[14:0], MISO};
  end

endmodule

// File: rtl/a2d_intf.sv
// A2D request responder: two SPI frames per conversion, 12-bit result with level cnv_cmplt.
// Build option A2D_RES_INV_EN: result is the bitwise inverse of the ADC data.
module a2d_intf
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  a2d_state_t  state;
  logic [2:0]  chnnl_l;
  logic        wrt;
  logic        done;
  logic [15:0] rd_data;
  logic        unused_rd_hi;

  function automatic logic [11:0] res_fmt(input logic [11:0] raw);
`ifdef A2D_RES_INV_EN
    return ~raw;
`else
    return raw;
`endif
  endfunction

  assign unused_rd_hi = ^rd_data[15:12];

  spi_mstr16 u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd_word(chnnl_l)),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (done),
    .rd_data (rd_data)
  );

  // wrt is a registered one-cycle strobe, so each frame starts the clk after it is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wrt       <= 1'b0;
      chnnl_l   <= '0;
      cnv_cmplt <= 1'b0;
      res       <= '0;
    end else begin
      wrt <= 1'b0;
      case (state)
        IDLE: if (strt_cnv) begin
          chnnl_l   <= chnnl;
          cnv_cmplt <= 1'b0;
          wrt       <= 1'b1;
          state     <= XFER1;
        end
        XFER1: if (done) begin
          wrt   <= 1'b1;
          state <= GAP;
        end
        GAP: state <= XFER2;
        XFER2: if (done) begin
          res       <= res_fmt(rd_data[11:0]);
          cnv_cmplt <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural ADC128S responder on the SPI pins.
module tb_a2d_intf;

`ifdef A2D_RES_INV_EN
  localparam bit RES_INV = 1'b1;
`else
  localparam bit RES_INV = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  a2d_intf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI monitor / ADC model
  logic [15:0] reply1 = 16'h0000;
  logic [15:0] reply2 = 16'h0000;
  int          xfer_base = 0;
  int          xfer_n = 0;
  int          k = 0;
  int          rises = 0;
  int          first_fall = -1;
  int          ss_hi_run = 0;
  int          last_gap = 0;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        prev_mosi = 1'b0;
  logic [15:0] mosi_word = '0;
  logic [15:0] cur_reply;
  logic [15:0] mosi_q[$];
  int          rise_q[$];
  int          ffall_q[$];

  initial MISO = 1'b0;

  always @(negedge clk) begin
    if (prev_ss && !SS_n) begin
      k = 0; rises = 0; first_fall = -1; mosi_word = '0;
      last_gap = ss_hi_run;
      xfer_n++;
    end else if (!SS_n) begin
      k++;
      if (prev_sclk && !SCLK) begin
        if (first_fall < 0) first_fall = k;
        mosi_word = {mosi_word[14:0], prev_mosi};
      end
      if (!prev_sclk && SCLK) rises++;
    end
    if (!prev_ss && SS_n) begin
      mosi_q.push_back(mosi_word);
      rise_q.push_back(rises);
      ffall_q.push_back(first_fall);
    end
    ss_hi_run = SS_n ? ss_hi_run + 1 : 0;
    cur_reply = ((xfer_n - xfer_base) == 1) ? reply1 : reply2;
    MISO = (rises < 16) ? cur_reply[15 - rises] : 1'b0;
    prev_ss = SS_n;
    prev_sclk = SCLK;
    prev_mosi = MOSI;
  end

  // Issue one request and wait (bounded) for completion. Called at negedge+1.
  task automatic conv(input logic [2:0] ch, input logic [15:0] r1, input logic [15:0] r2,
                      input int glitch_at, output int lat, output logic c1, output int base);
    int n;
    reply1 = r1;
    reply2 = r2;
    xfer_base = xfer_n;
    base = mosi_q.size();
    chnnl = ch;
    strt_cnv = 1'b1;
    lat = -1;
    c1 = 1'bx;
    n = 0;
    while (n < 1300 && lat < 0) begin
      @(negedge clk); #1;
      n++;
      strt_cnv = (n == glitch_at);
      if (n == glitch_at) chnnl = 3'd7;
      if (n == 1) c1 = cnv_cmplt;
      if (cnv_cmplt) lat = n - 1;
    end
  endtask

  int   lat;
  logic c1;
  int   base;
  logic quiet;

  initial begin
    rst_n = 1'b0;
    strt_cnv = 1'b0;
    chnnl = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ss_n", SS_n, 1'b1);
    chk("rst_sclk", SCLK, 1'b1);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_cmplt", cnv_cmplt, 1'b0);
    chk("rst_res", res, 12'h000);
    rst_n = 1'b1;

    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk); #1;
      if (!(SS_n === 1'b1 && SCLK === 1'b1 && MOSI === 1'b0 && cnv_cmplt === 1'b0 && res === 12'h000))
        quiet = 1'b0;
    end
    chk("idle_quiet", quiet, 1'b1);

    // Basic conversion, channel 5
    conv(3'd5, 16'hF123, 16'h0ABC, -1, lat, c1, base);
    chk("ch5_lat", lat, 1042);
    chk("ch5_res", res, RES_INV ? 12'h543 : 12'hABC);
    chk("ch5_nxfer", mosi_q.size() - base, 2);
    chk("ch5_mosi1", mosi_q[base], 16'h2800);
    chk("ch5_mosi2", mosi_q[base + 1], 16'h2800);
    chk("ch5_rises1", rise_q[base], 16);
    chk("ch5_rises2", rise_q[base + 1], 16);
    chk("ch5_ffall1", ffall_q[base], 9);
    chk("ch5_ffall2", ffall_q[base + 1], 9);
    chk("ch5_gap", last_gap, 1);

    // Request during a conversion is ignored
    repeat (5) @(negedge clk);
    #1;
    conv(3'd2, 16'h3333, 16'h0456, 300, lat, c1, base);
    chk("ign_lat", lat, 1042);
    chk("ign_res", res, RES_INV ? 12'hBA9 : 12'h456);
    chk("ign_mosi1", mosi_q[base], 16'h1000);
    chk("ign_mosi2", mosi_q[base + 1], 16'h1000);
    repeat (1200) @(negedge clk);
    #1;
    chk("ign_nxfer", xfer_n - xfer_base, 2);
    chk("ign_cmplt_held", cnv_cmplt, 1'b1);

    // Reset in the middle of a conversion
    chnnl = 3'd3;
    strt_cnv = 1'b1;
    @(negedge clk); #1;
    strt_cnv = 1'b0;
    repeat (599) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ss_n", SS_n, 1'b1);
    chk("abort_sclk", SCLK, 1'b1);
    chk("abort_mosi", MOSI, 1'b0);
    chk("abort_cmplt", cnv_cmplt, 1'b0);
    chk("abort_res", res, 12'h000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    conv(3'd1, 16'h7777, 16'h0123, -1, lat, c1, base);
    chk("post_rst_lat", lat, 1042);
    chk("post_rst_res", res, RES_INV ? 12'hEDC : 12'h123);
    chk("post_rst_mosi", mosi_q[base], 16'h0800);

    // Back-to-back requests
    conv(3'd6, 16'h0000, 16'hCFFF, -1, lat, c1, base);
    chk("b2b1_lat", lat, 1042);
    chk("b2b1_res", res, RES_INV ? 12'h000 : 12'hFFF);
    conv(3'd0, 16'hAAAA, 16'h0000, -1, lat, c1, base);
    chk("b2b2_drop", c1, 1'b0);
    chk("b2b2_lat", lat, 1042);
    chk("b2b2_res", res, RES_INV ? 12'hFFF : 12'h000);
    chk("b2b2_mosi", mosi_q[base], 16'h0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
